// File: rtl/temporizador_lavagem_if.sv
// Mode/timer bundle between the washing-machine controller and its phase timer.
// Controller drives modes and reads elapsed flags; the timer does the reverse.
interface temporizador_lavagem_if #(
  parameter int CNT_W = 8
);
  logic             modo_agitar;
  logic             modo_girar;
  logic             modo_centrifugar;
  logic             tempo1;
  logic             tempo2;
  logic             tempo3;
  logic [CNT_W-1:0] segundos_rest;
  logic             ocupado;
  logic             erro_modo;

  modport master (
    output modo_agitar,
    output modo_girar,
    output modo_centrifugar,
    input  tempo1,
    input  tempo2,
    input  tempo3,
    input  segundos_rest,
    input  ocupado,
    input  erro_modo
  );

  modport slave (
    input  modo_agitar,
    input  modo_girar,
    input  modo_centrifugar,
    output tempo1,
    output tempo2,
    output tempo3,
    output segundos_rest,
    output ocupado,
    output erro_modo
  );
endinterface

// File: rtl/temporizador_lavagem.sv
// Phase timer for the washing-machine controller: times the active mode
// in seconds and raises the matching tempo flag when it elapses.
module temporizador_lavagem #(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = 8,
  parameter int T1      = 30,
  parameter int T2      = 20,
  parameter int T3      = 40
) (
  input logic              clock,
  input logic              reset_n,
  temporizador_lavagem_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    CONTANDO,
    EXPIRADO
  } estado_t;

  estado_t          estado;
  logic [2:0]       lat;
  logic [CNT_W-1:0] cont;
  logic [PW-1:0]    presc;
  logic [2:0]       tempo_q;
  logic [CNT_W-1:0] seg_q;
  logic             ocup_q;
  logic             erro_q;

  logic [2:0]       modo;
  logic             multi;
  logic             unico;
  logic             carregar;
  logic [CNT_W-1:0] t_novo;

  assign modo  = {bus.modo_centrifugar,
                  bus.modo_girar,
                  bus.modo_agitar};
  assign multi = |(modo & (modo - 3'd1));
  assign unico = (modo != 3'd0) && !multi;

  // A new single mode loads from idle, or replaces the latched one
  // without an idle gap.
  assign carregar = unico &&
                    (estado == OCIOSO || modo != lat);

  always_comb begin
    t_novo = '0;
    unique case (modo)
      3'b001:  t_novo = CNT_W'(T1);
      3'b010:  t_novo = CNT_W'(T2);
      3'b100:  t_novo = CNT_W'(T3);
      default: t_novo = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= OCIOSO;
      lat     <= '0;
      cont    <= '0;
      presc   <= '0;
      tempo_q <= '0;
      seg_q   <= '0;
      ocup_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      erro_q <= multi;
      if (multi) begin
        estado  <= OCIOSO;
        lat     <= '0;
        tempo_q <= '0;
        seg_q   <= '0;
        ocup_q  <= 1'b0;
      end else if (carregar) begin
        lat   <= modo;
        cont  <= t_novo;
        presc <= '0;
        if (t_novo == '0) begin
          estado  <= EXPIRADO;
          tempo_q <= modo;
          seg_q   <= '0;
          ocup_q  <= 1'b0;
        end else begin
          estado  <= CONTANDO;
          tempo_q <= '0;
          seg_q   <= t_novo;
          ocup_q  <= 1'b1;
        end
      end else if (modo == 3'd0) begin
        estado  <= OCIOSO;
        lat     <= '0;
        tempo_q <= '0;
        seg_q   <= '0;
        ocup_q  <= 1'b0;
      end else if (estado == CONTANDO) begin
        if (presc == PMAX) begin
          presc <= '0;
          cont  <= cont - CNT_W'(1);
          if (cont == CNT_W'(1)) begin
            estado  <= EXPIRADO;
            tempo_q <= lat;
            seg_q   <= '0;
            ocup_q  <= 1'b0;
          end else begin
            seg_q <= cont - CNT_W'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign bus.tempo1        = tempo_q[0];
  assign bus.tempo2        = tempo_q[1];
  assign bus.tempo3        = tempo_q[2];
  assign bus.segundos_rest = seg_q;
  assign bus.ocupado       = ocup_q;
  assign bus.erro_modo     = erro_q;

endmodule

// File: tb/tb_temporizador_lavagem.sv
// Bench for temporizador_lavagem: elapsed-time reference model, directed
// scenarios with hand-computed expectations, then random mode traffic.
module tb_temporizador_lavagem;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 8;
  localparam int T1      = 3;
  localparam int T2      = 2;
  localparam int T3      = 0;

  logic clock;
  logic reset_n;

  temporizador_lavagem_if #(.CNT_W(CNT_W)) bus ();

  temporizador_lavagem #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W),
    .T1     (T1),
    .T2     (T2),
    .T3     (T3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference: which phase is active and how many edges since its load.
  int m_mode;
  int m_k;
  bit m_err;

  function automatic int dur(input int md);
    case (md)
      1:       return T1;
      2:       return T2;
      4:       return T3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    int v;
    if (!reset_n) begin
      m_mode = 0;
      m_k    = 0;
      m_err  = 0;
    end else begin
      v = {bus.modo_centrifugar, bus.modo_girar, bus.modo_agitar};
      m_err = ($countones(v) > 1);
      if (m_err) m_mode = 0;
      else if (v != 0 && v != m_mode) begin
        m_mode = v;
        m_k    = 0;
      end else if (v == 0) m_mode = 0;
      else if (m_k < 100000) m_k++;
    end
  end

  task automatic model_out(output logic [2:0] t, output int seg,
                           output logic oc);
    int d;
    t = 3'b000; seg = 0; oc = 1'b0;
    if (m_mode != 0) begin
      d = dur(m_mode);
      if (m_k >= d * CLK_DIV) t = 3'(m_mode);
      else begin
        seg = d - m_k / CLK_DIV;
        oc  = 1'b1;
      end
    end
  endtask

  always @(negedge clock) begin
    logic [2:0] et, gt;
    int es;
    logic eo;
    if (reset_n) begin
      model_out(et, es, eo);
      gt = {bus.tempo3, bus.tempo2, bus.tempo1};
      vectors++;
      if (gt !== et || bus.segundos_rest !== 8'(es) ||
          bus.ocupado !== eo || bus.erro_modo !== m_err) begin
        miscompares++;
        $display("FAIL model t=%0t tempo=%b/%b seg=%0d/%0d ocup=%b/%b erro=%b/%b (got/required)",
                 $time, gt, et, bus.segundos_rest, es, bus.ocupado, eo,
                 bus.erro_modo, m_err);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  task automatic setm(input logic [2:0] v);
    {bus.modo_centrifugar, bus.modo_girar, bus.modo_agitar} = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    setm(3'b000);
    cyc(2);
    chk("reset_seg", bus.segundos_rest, 0);
    chk("reset_ocup", bus.ocupado, 0);
    reset_n = 1'b1;
    cyc(3);
    chk("idle_ocup", bus.ocupado, 0);

    // Agitate: 3,2,1 each four cycles, tempo1 twelve edges after load.
    setm(3'b001);
    for (int i = 0; i <= 12; i++) begin
      cyc(1);
      chk($sformatf("agit_seg%0d", i), bus.segundos_rest,
          (i < 12) ? 3 - i / 4 : 0);
      chk($sformatf("agit_t1_%0d", i), bus.tempo1, (i == 12) ? 1 : 0);
    end
    cyc(3);
    chk("agit_hold", bus.tempo1, 1);
    setm(3'b000);
    cyc(1);
    chk("agit_drop", bus.tempo1, 0);
    cyc(2);

    // Abort after five edges, then a full re-raise.
    setm(3'b010);
    cyc(5);
    setm(3'b000);
    cyc(1);
    chk("abort_ocup", bus.ocupado, 0);
    chk("abort_t2", bus.tempo2, 0);
    cyc(2);
    setm(3'b010);
    cyc(8);
    chk("rerise_t2_e7", bus.tempo2, 0);
    cyc(1);
    chk("rerise_t2_e8", bus.tempo2, 1);
    setm(3'b000);
    cyc(2);

    // Zero duration centrifuge.
    setm(3'b100);
    cyc(1);
    chk("zero_t3", bus.tempo3, 1);
    chk("zero_ocup", bus.ocupado, 0);
    setm(3'b000);
    cyc(2);

    // Direct switch agitate -> turn.
    setm(3'b001);
    cyc(6);
    setm(3'b010);
    cyc(1);
    chk("switch_seg", bus.segundos_rest, 2);
    cyc(7);
    chk("switch_t2_e7", bus.tempo2, 0);
    cyc(1);
    chk("switch_t2_e8", bus.tempo2, 1);
    chk("switch_t1", bus.tempo1, 0);
    setm(3'b000);
    cyc(2);

    // Invalid combination then fall back to agitate.
    setm(3'b011);
    cyc(1);
    chk("inv_erro", bus.erro_modo, 1);
    chk("inv_ocup", bus.ocupado, 0);
    setm(3'b001);
    cyc(1);
    chk("inv_clear", bus.erro_modo, 0);
    chk("inv_fresh", bus.segundos_rest, 3);
    cyc(5);

    // Asynchronous reset mid-count, observed between edges.
    #2 reset_n = 1'b0;
    #1;
    chk("areset_seg", bus.segundos_rest, 0);
    chk("areset_ocup", bus.ocupado, 0);
    chk("areset_t", {bus.tempo3, bus.tempo2, bus.tempo1}, 0);
    setm(3'b000);
    cyc(1);
    reset_n = 1'b1;
    cyc(3);

    // Random phases, mostly valid with occasional invalid combos.
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    setm(3'b000);
        2, 3, 4: setm(3'b001);
        5, 6:    setm(3'b010);
        7:       setm(3'b100);
        default: setm(3'($urandom_range(3, 7)));
      endcase
      cyc($urandom_range(1, 16));
      if (n == 120) begin
        #2 reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
      end
    end
    setm(3'b000);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
